// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester bridge.
//   - apb_state_e     : bridge FSM states (IDLE, SETUP, ACCESS, RDWAIT)
//   - APB_AW / APB_DW : default address / data widths
//   - TIMEOUT_DISABLE : watchdog setting that turns the abort logic off
//   - wd_width()      : watchdog counter width for a given timeout setting
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RDWAIT = 2'd3
    } apb_state_e;

    localparam int APB_AW          = 32;
    localparam int APB_DW          = 32;
    localparam int TIMEOUT_DISABLE = 0;

    // $clog2(1) is 0, so a disabled watchdog still gets a 1-bit counter
    // to keep every vector at a legal width.
    function automatic int wd_width(input int timeout_cycles);
        if (timeout_cycles > 0) begin
            return $clog2(timeout_cycles + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// APB3 requester: takes single-beat commands on a valid/ready port, runs one
// APB SETUP/ACCESS transfer per command and returns a one-cycle response.
//
// Ports
//   pclk, presetn          : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready  : command handshake (ready == bridge idle)
//   cmd_write/addr/wdata   : command direction, address, write data
//   rsp_valid              : one-cycle response strobe (no backpressure)
//   rsp_rdata              : read data (0 for writes and aborted transfers)
//   rsp_err / rsp_timeout  : slave error or abort / watchdog abort
//   paddr, pwdata, pwrite, psel, penable : APB requester outputs
//   prdata, pready, pslverr               : APB completer inputs
//
// RDATA_LAT = 1 supports slaves that register prdata on the access edge: the
// bridge spends one extra RDWAIT cycle and samples prdata there.
// TIMEOUT_CYCLES = 0 lets ACCESS wait forever.
// -----------------------------------------------------------------------------
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int AW             = APB_AW,
    parameter int DW             = APB_DW,
    parameter int RDATA_LAT      = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_timeout,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    output logic          pwrite,
    output logic          psel,
    output logic          penable,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslverr
);

    localparam int WD_W = wd_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);
    localparam logic [WD_W-1:0] WD_SAT = {WD_W{1'b1}};
    // Count value on the last permitted ACCESS cycle.
    localparam logic [WD_W-1:0] WD_HIT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam bit WD_ENABLED = (TIMEOUT_CYCLES != TIMEOUT_DISABLE);
    localparam bit LAT0       = (RDATA_LAT == 0);

    apb_state_e    state_r,       state_s;
    logic          psel_r,        psel_s;
    logic          penable_r,     penable_s;
    logic          pwrite_r,      pwrite_s;
    logic [AW-1:0] paddr_r,       paddr_s;
    logic [DW-1:0] pwdata_r,      pwdata_s;
    logic [WD_W-1:0] wd_r,        wd_s;
    logic          err_cap_r,     err_cap_s;
    logic          rsp_valid_r,   rsp_valid_s;
    logic [DW-1:0] rsp_rdata_r,   rsp_rdata_s;
    logic          rsp_err_r,     rsp_err_s;
    logic          rsp_timeout_r, rsp_timeout_s;
    logic          wd_hit_s;

    assign cmd_ready   = (state_r == IDLE);
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwrite      = pwrite_r;
    assign paddr       = paddr_r;
    assign pwdata      = pwdata_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;

    // Watchdog expiry: enabled and this is the last allowed ACCESS cycle.
    always_comb begin
        wd_hit_s = WD_ENABLED && (wd_r == WD_HIT);
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s       = state_r;
        psel_s        = psel_r;
        penable_s     = penable_r;
        pwrite_s      = pwrite_r;
        paddr_s       = paddr_r;
        pwdata_s      = pwdata_r;
        wd_s          = wd_r;
        err_cap_s     = err_cap_r;
        rsp_valid_s   = 1'b0;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_err_s     = rsp_err_r;
        rsp_timeout_s = rsp_timeout_r;

        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_s  = cmd_write;
                    paddr_s   = cmd_addr;
                    pwdata_s  = cmd_wdata;
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
                    state_s   = SETUP;
                end else begin
                    state_s   = IDLE;
                end
            end
            SETUP: begin
                penable_s = 1'b1;
                wd_s      = '0;
                state_s   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                    if (pwrite_r || LAT0) begin
                        rsp_valid_s   = 1'b1;
                        rsp_err_s     = pslverr;
                        rsp_timeout_s = 1'b0;
                        rsp_rdata_s   = pwrite_r ? '0 : prdata;
                        state_s       = IDLE;
                    end else begin
                        // Slave registers prdata on this edge; take it next cycle.
                        err_cap_s = pslverr;
                        state_s   = RDWAIT;
                    end
                end else if (wd_hit_s) begin
                    psel_s        = 1'b0;
                    penable_s     = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_err_s     = 1'b1;
                    rsp_timeout_s = 1'b1;
                    rsp_rdata_s   = '0;
                    state_s       = IDLE;
                end else begin
                    if (wd_r != WD_SAT) begin
                        wd_s = wd_r + WD_ONE;
                    end else begin
                        wd_s = wd_r;
                    end
                end
            end
            RDWAIT: begin
                rsp_valid_s   = 1'b1;
                rsp_rdata_s   = prdata;
                rsp_err_s     = err_cap_r;
                rsp_timeout_s = 1'b0;
                state_s       = IDLE;
            end
            default: begin
                psel_s    = 1'b0;
                penable_s = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops APB outputs immediately.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r       <= IDLE;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= '0;
            pwdata_r      <= '0;
            wd_r          <= '0;
            err_cap_r     <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            psel_r        <= psel_s;
            penable_r     <= penable_s;
            pwrite_r      <= pwrite_s;
            paddr_r       <= paddr_s;
            pwdata_r      <= pwdata_s;
            wd_r          <= wd_s;
            err_cap_r     <= err_cap_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_err_r     <= rsp_err_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB3 requester. Converts single-beat commands from an internal valid/ready port into APB SETUP/ACCESS transfers, and returns read data and status on a one-cycle response strobe.
- Drives the team's APB register slaves from firmware-model and test-sequencer logic.
- Supports wait states via pready, error reporting via pslverr, a registered-read-data slave option, and a watchdog that aborts hung transfers.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RDATA_LAT, 1, cycles after ACCESS completion at which prdata is sampled. Legal values are 0 and 1. Use 1 for the team's register slaves, which register prdata on the access edge.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort. 0 disables the watchdog.

Ports:
- pclk  in  1  APB clock; the single clock.
- presetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  transfer address.
- cmd_wdata  in  DW  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DW  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr or timeout.
- rsp_timeout  out  1  transfer aborted by the watchdog.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- prdata  in  DW  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (presetn low, asynchronous):
  - psel, penable, pwrite = 0; paddr, pwdata = 0.
  - rsp_valid, rsp_err, rsp_timeout = 0; rsp_rdata = 0.
  - State = IDLE; watchdog count = 0.
- Reset asserted mid-transfer: the in-flight command is dropped, no response is issued, and APB outputs drop immediately.
- States: IDLE, SETUP, ACCESS, RDWAIT.
- cmd_ready = (state == IDLE), combinational. It is therefore high during reset.
- IDLE:
  - On cmd_valid && cmd_ready, latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata.
  - Set psel = 1, penable = 0, go to SETUP.
- SETUP (exactly 1 cycle): set penable = 1, clear watchdog count, go to ACCESS.
- ACCESS, sampling pready at each rising edge:
  - pready = 1, and the transfer is a write or RDATA_LAT = 0:
    - psel = penable = 0; go to IDLE.
    - rsp_valid <= 1; rsp_err <= pslverr; rsp_timeout <= 0.
    - rsp_rdata <= prdata for reads, 0 for writes.
  - pready = 1, read with RDATA_LAT = 1:
    - psel = penable = 0; capture pslverr; go to RDWAIT.
  - pready = 0, and the watchdog is enabled with count == TIMEOUT_CYCLES-1:
    - Abort: psel = penable = 0; go to IDLE.
    - rsp_valid <= 1; rsp_err <= 1; rsp_timeout <= 1; rsp_rdata <= 0.
  - Otherwise: hold all APB outputs stable and increment the count.
  - The count saturates and does not wrap. With TIMEOUT_CYCLES = 0, ACCESS waits indefinitely.
- RDWAIT (exactly 1 cycle): rsp_rdata <= prdata; rsp_err <= captured pslverr; rsp_valid <= 1; go to IDLE.
- rsp_valid is high for exactly one cycle. There is no response backpressure; the consumer must take it.
- rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
- Throughput:
  - A new command may be accepted in the same cycle rsp_valid is high, since state is IDLE.
  - Minimum spacing is 3 cycles per write or RDATA_LAT = 0 read, and 4 per RDATA_LAT = 1 read.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS. After the transfer they retain their last values.
- pslverr and prdata are ignored whenever pready = 0 or the state is not ACCESS/RDWAIT.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RDWAIT);
  - APB_AW/APB_DW default constants;
  - the timeout-disable constant (0).
- No sub-module; the watchdog is an inline saturating counter of width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Write: cmd_write=1, cmd_addr=0x8, cmd_wdata=0xCAFE_F00D, pready tied 1.
  - Required: psel high 2 cycles, penable high 1 cycle (2nd), pwdata=0xCAFE_F00D throughout.
  - Required: rsp_valid pulses the next cycle with rsp_err=0 and rsp_rdata=0.
- Read: RDATA_LAT=1, addr 0x4, slave model registers prdata=0x5A5A_5555 on the access edge.
  - Required: RDWAIT for 1 cycle, then rsp_rdata=0x5A5A_5555, rsp_err=0, 4 cycles from accept to response.
- Wait states: write with pready low for 3 ACCESS cycles, then high.
  - Required: ACCESS lasts 4 cycles and paddr/pwdata/pwrite stay stable throughout.
  - Required: rsp_valid arrives 1 cycle after pready, no timeout.
- Timeout: TIMEOUT_CYCLES=16, pready stuck 0.
  - Required: abort after 16 ACCESS cycles with psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Required: a following command is accepted normally.
- Slave error: read from 0x20 with pslverr=1 on the ready edge, prdata=0xDEAD_DEAD next cycle.
  - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0xDEAD_DEAD.
- Reset and back-to-back:
  - presetn pulsed low during ACCESS: psel/penable drop without a clock edge, no rsp_valid, cmd_ready=1 after release.
  - cmd_valid held high for three writes: accepted every 3 cycles, three single-cycle rsp_valid pulses.
